// File: rtl/game_pkg.sv
// Shared constants for the game controller: scan codes, FSM encoding,
// command bit positions and keyboard-word decode helpers.
package game_pkg;

  // Keyboard word field positions
  localparam int KE_VALID = 10;
  localparam int KE_EXT   = 9;
  localparam int KE_REL   = 8;

  // Scan codes (set 2, make codes)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_M     = 8'h3A;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_R     = 8'h2D;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  // Command bit indices within cmd1/cmd2
  localparam int CMD_ROT   = 3;
  localparam int CMD_LEFT  = 2;
  localparam int CMD_DROP  = 1;
  localparam int CMD_RIGHT = 0;

  // The keyboard front end delivers the scan code LSB-first; undo that.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  // Player 1 keys (no E0 prefix): W/A/S/D
  function automatic logic [3:0] p1_cmd(input logic [7:0] code);
    logic [3:0] r;
    r = 4'b0000;
    case (code)
      SC_W:    r[CMD_ROT]   = 1'b1;
      SC_A:    r[CMD_LEFT]  = 1'b1;
      SC_S:    r[CMD_DROP]  = 1'b1;
      SC_D:    r[CMD_RIGHT] = 1'b1;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Player 2 keys (E0-prefixed arrows)
  function automatic logic [3:0] p2_cmd(input logic [7:0] code);
    logic [3:0] r;
    r = 4'b0000;
    case (code)
      SC_UP:    r[CMD_ROT]   = 1'b1;
      SC_LEFT:  r[CMD_LEFT]  = 1'b1;
      SC_DOWN:  r[CMD_DROP]  = 1'b1;
      SC_RIGHT: r[CMD_RIGHT] = 1'b1;
      default:  r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/game_ctrl_key_repeat.sv
// Held-drop tracker for one player: remembers that the drop key is down and
// times the auto-repeat (first repeat after REP_DLY, then every REP_PER).
module key_repeat #(
  parameter int REP_DLY = 25_000_000,
  parameter int REP_PER = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_press,    // accepted drop press while RUN or PAUSE
  input  logic i_release,  // accepted drop release
  input  logic i_run,      // game is running: counter advances
  input  logic i_hold,     // game is paused: counter freezes
  output logic o_fire      // repeat pulse request (registered by the top)
);

  localparam int CW = $clog2(REP_DLY + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(REP_DLY - 1);
  // After the first repeat, reload so the next hit of LAST_CNT is REP_PER away
  localparam logic [CW-1:0] RELOAD   = CW'(REP_DLY - REP_PER);

  logic          r_held;
  logic [CW-1:0] r_cnt;
  logic          w_fire;

  // A release in the same cycle suppresses a due repeat; a press restarts timing
  assign w_fire = r_held && i_run && !i_press && !i_release && (r_cnt == LAST_CNT);
  assign o_fire = w_fire;

  // Held flag and repeat counter; cleared whenever the game is neither running nor paused
  always_ff @(posedge clk) begin
    if (reset) begin
      r_held <= 1'b0;
      r_cnt  <= '0;
    end else if (i_press) begin
      r_held <= 1'b1;
      r_cnt  <= '0;
    end else if (i_release || (!i_run && !i_hold)) begin
      r_held <= 1'b0;
      r_cnt  <= '0;
    end else if (i_run && r_held) begin
      r_held <= 1'b1;
      r_cnt  <= w_fire ? RELOAD : (r_cnt + CW'(1));
    end else begin
      r_held <= r_held;
      r_cnt  <= r_cnt;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game controller: decodes keyboard words into per-player command pulses,
// runs the IDLE/RUN/PAUSE/OVER state machine, level select, music and result.
module game_ctrl
  import game_pkg::*;
#(
  parameter int REP_DLY = 25_000_000,
  parameter int REP_PER = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] key_event,
  input  logic        over1,
  input  logic        over2,
  output logic [3:0]  cmd1,
  output logic [3:0]  cmd2,
  output logic        run,
  output logic        clr,
  output logic        music_en,
  output logic [3:0]  sel,
  output logic [1:0]  state,
  output logic [1:0]  winner
);

  logic [9:0] r_last;
  logic [1:0] r_state;
  logic       r_run;
  logic       r_clr;
  logic [3:0] r_cmd1;
  logic [3:0] r_cmd2;
  logic       r_music;
  logic [3:0] r_sel;
  logic [1:0] r_winner;

  logic [7:0] w_code;
  logic       w_ext;
  logic       w_accept;
  logic       w_press;
  logic       w_release;
  logic       w_plain_press;
  logic       w_key_r;
  logic       w_key_space;
  logic       w_key_p;
  logic       w_key_m;
  logic [3:0] w_p1_cmd;
  logic [3:0] w_p2_cmd;
  logic       w_p1_drop_rel;
  logic       w_p2_drop_rel;
  logic       w_rep_armed;
  logic       w_rep1;
  logic       w_rep2;
  logic       w_sel_inc;
  logic       w_stay_run;
  logic [1:0] w_next;
  logic [3:0] w_cmd1_next;
  logic [3:0] w_cmd2_next;

  // Key decode: only a valid word that differs from the last accepted one counts
  assign w_code        = rev8(key_event[7:0]);
  assign w_ext         = key_event[KE_EXT];
  assign w_accept      = key_event[KE_VALID] && (key_event[9:0] != r_last);
  assign w_press       = w_accept && !key_event[KE_REL];
  assign w_release     = w_accept && key_event[KE_REL];
  assign w_plain_press = w_press && !w_ext;
  assign w_key_r       = w_plain_press && (w_code == SC_R);
  assign w_key_space   = w_plain_press && (w_code == SC_SPACE);
  assign w_key_p       = w_plain_press && (w_code == SC_P);
  assign w_key_m       = w_plain_press && (w_code == SC_M);
  assign w_p1_cmd      = w_plain_press ? p1_cmd(w_code) : 4'b0000;
  assign w_p2_cmd      = (w_press && w_ext) ? p2_cmd(w_code) : 4'b0000;
  assign w_p1_drop_rel = w_release && !w_ext && (w_code == SC_S);
  assign w_p2_drop_rel = w_release && w_ext && (w_code == SC_DOWN);
  assign w_rep_armed   = (r_state == ST_RUN) || (r_state == ST_PAUSE);
  assign w_sel_inc     = (r_state == ST_IDLE) && (w_p1_cmd[CMD_ROT] || w_p2_cmd[CMD_ROT]);
  assign w_stay_run    = (r_state == ST_RUN) && (w_next == ST_RUN);

  key_repeat #(.REP_DLY(REP_DLY), .REP_PER(REP_PER)) u_rep1 (
    .clk       (clk),
    .reset     (reset),
    .i_press   (w_p1_cmd[CMD_DROP] && w_rep_armed),
    .i_release (w_p1_drop_rel),
    .i_run     (r_state == ST_RUN),
    .i_hold    (r_state == ST_PAUSE),
    .o_fire    (w_rep1)
  );

  key_repeat #(.REP_DLY(REP_DLY), .REP_PER(REP_PER)) u_rep2 (
    .clk       (clk),
    .reset     (reset),
    .i_press   (w_p2_cmd[CMD_DROP] && w_rep_armed),
    .i_release (w_p2_drop_rel),
    .i_run     (r_state == ST_RUN),
    .i_hold    (r_state == ST_PAUSE),
    .o_fire    (w_rep2)
  );

  // Next-state logic; R overrides everything, including a same-cycle top-out
  always_comb begin
    w_next = r_state;
    if (w_key_r) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = w_key_space ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (over1 || over2) begin
            w_next = ST_OVER;
          end else if (w_key_p) begin
            w_next = ST_PAUSE;
          end else begin
            w_next = ST_RUN;
          end
        end
        ST_PAUSE: w_next = w_key_space ? ST_RUN : ST_PAUSE;
        ST_OVER:  w_next = ST_OVER;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Command words: pulses only while the game is and stays running
  always_comb begin
    w_cmd1_next = 4'b0000;
    w_cmd2_next = 4'b0000;
    if (w_stay_run) begin
      w_cmd1_next           = w_p1_cmd;
      w_cmd1_next[CMD_DROP] = w_p1_cmd[CMD_DROP] | w_rep1;
      w_cmd2_next           = w_p2_cmd;
      w_cmd2_next[CMD_DROP] = w_p2_cmd[CMD_DROP] | w_rep2;
    end else begin
      w_cmd1_next = 4'b0000;
      w_cmd2_next = 4'b0000;
    end
  end

  // Last-accepted word, FSM state and the run/clr/cmd outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last  <= 10'd0;
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
      r_clr   <= 1'b1;
      r_cmd1  <= 4'b0000;
      r_cmd2  <= 4'b0000;
    end else begin
      r_last  <= w_accept ? key_event[9:0] : r_last;
      r_state <= w_next;
      r_run   <= (w_next == ST_RUN);
      r_clr   <= w_key_r;
      r_cmd1  <= w_cmd1_next;
      r_cmd2  <= w_cmd2_next;
    end
  end

  // Music toggle (untouched by R) and level select (only changes in IDLE)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_music <= 1'b0;
      r_sel   <= 4'd0;
    end else begin
      r_music <= r_music ^ w_key_m;
      if (w_key_r) begin
        r_sel <= 4'd0;
      end else if (w_sel_inc) begin
        r_sel <= r_sel + 4'd1;
      end else begin
        r_sel <= r_sel;
      end
    end
  end

  // Result latch: {over1,over2} on entry to OVER gives 10 (P2 wins), 01 (P1 wins) or 11
  always_ff @(posedge clk) begin
    if (reset) begin
      r_winner <= 2'b00;
    end else if (w_key_r) begin
      r_winner <= 2'b00;
    end else if ((r_state == ST_RUN) && (w_next == ST_OVER)) begin
      r_winner <= {over1, over2};
    end else begin
      r_winner <= r_winner;
    end
  end

  assign cmd1     = r_cmd1;
  assign cmd2     = r_cmd2;
  assign run      = r_run;
  assign clr      = r_clr;
  assign music_en = r_music;
  assign sel      = r_sel;
  assign state    = r_state;
  assign winner   = r_winner;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with short repeat timing.
module tb_game_ctrl;

  localparam int P_DLY = 10;
  localparam int P_PER = 4;

  localparam logic [7:0] K_W = 8'h1D, K_A = 8'h1C, K_S = 8'h1B;
  localparam logic [7:0] K_LEFT = 8'h6B, K_M = 8'h3A, K_P = 8'h4D;
  localparam logic [7:0] K_SPACE = 8'h29, K_R = 8'h2D;

  logic        clk;
  logic        reset;
  logic [10:0] key_event;
  logic        over1, over2;
  logic [3:0]  cmd1, cmd2;
  logic        run, clr, music_en;
  logic [3:0]  sel;
  logic [1:0]  state, winner;

  int n_checks = 0;
  int n_fail   = 0;

  game_ctrl #(.REP_DLY(P_DLY), .REP_PER(P_PER)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_event (key_event),
    .over1     (over1),
    .over2     (over2),
    .cmd1      (cmd1),
    .cmd2      (cmd2),
    .run       (run),
    .clr       (clr),
    .music_en  (music_en),
    .sel       (sel),
    .state     (state),
    .winner    (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Build a valid keyboard word; the code is placed LSB-first on the bus
  function automatic logic [10:0] key_word(input logic ext, input logic rel, input logic [7:0] code);
    logic [10:0] w;
    w = {1'b1, ext, rel, 8'h00};
    for (int i = 0; i < 8; i++) begin
      w[i] = code[7-i];
    end
    return w;
  endfunction

  // One clock, then settle past the edge before looking at outputs
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_c;
    int pulses;

    reset = 1'b1; key_event = 11'd0; over1 = 1'b0; over2 = 1'b0;
    cyc(); cyc();
    check_val("rst_clr", {7'd0, clr}, 8'd1);
    check_val("rst_state", {6'd0, state}, 8'd0);
    check_val("rst_cmd", {cmd1, cmd2}, 8'd0);
    check_val("rst_run", {7'd0, run}, 8'd0);
    check_val("rst_music", {7'd0, music_en}, 8'd0);
    check_val("rst_sel", {4'd0, sel}, 8'd0);
    check_val("rst_winner", {6'd0, winner}, 8'd0);
    reset = 1'b0;
    cyc();
    check_val("clr_drop", {7'd0, clr}, 8'd0);

    // IDLE: a P1 key does not produce a command
    key_event = key_word(1'b0, 1'b0, K_A); cyc();
    check_val("idle_nocmd", {4'd0, cmd1}, 8'd0);

    // Space starts the game
    key_event = key_word(1'b0, 1'b0, K_SPACE); cyc();
    check_val("start_state", {6'd0, state}, 8'h01);
    check_val("start_run", {7'd0, run}, 8'd1);
    check_val("start_clr", {7'd0, clr}, 8'd0);

    // Single-cycle lateral pulses, then a held word produces nothing more
    key_event = key_word(1'b0, 1'b0, K_A); cyc();
    check_val("p1_left", {4'd0, cmd1}, 8'h04);
    check_val("p1_left_p2", {4'd0, cmd2}, 8'h00);
    key_event = key_word(1'b1, 1'b0, K_LEFT); cyc();
    check_val("p2_left_p1", {4'd0, cmd1}, 8'h00);
    check_val("p2_left", {4'd0, cmd2}, 8'h04);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if ((cmd1 | cmd2) != 4'b0000) pulses++;
    end
    check_val("held_no_repeat", pulses[7:0], 8'd0);

    // Non-extended arrow code is not a P2 key
    key_event = key_word(1'b0, 1'b0, K_LEFT); cyc();
    check_val("plain_arrow", {cmd1, cmd2}, 8'd0);

    // Hold S for 30 cycles, then release: drops at +1,+11,+15,+19,+23,+27
    key_event = key_word(1'b0, 1'b0, K_S);
    for (int k = 1; k <= 40; k++) begin
      if (k == 31) key_event = key_word(1'b0, 1'b1, K_S);
      cyc();
      exp_c = (k == 1 || k == 11 || k == 15 || k == 19 || k == 23 || k == 27) ? 4'b0010 : 4'b0000;
      check_val($sformatf("drop_k%0d", k), {cmd2, cmd1}, {4'b0000, exp_c});
    end

    // Pause and resume
    key_event = key_word(1'b0, 1'b0, K_P); cyc();
    check_val("pause", {6'd0, state}, 8'h02);
    check_val("pause_run", {7'd0, run}, 8'd0);
    key_event = key_word(1'b0, 1'b0, K_SPACE); cyc();
    check_val("resume", {6'd0, state}, 8'h01);

    // Both top-outs together: tie, then P ignored, then R restarts
    over1 = 1'b1; over2 = 1'b1; cyc();
    over1 = 1'b0; over2 = 1'b0;
    check_val("over_state", {6'd0, state}, 8'h03);
    check_val("over_tie", {6'd0, winner}, 8'h03);
    key_event = key_word(1'b0, 1'b0, K_P); cyc();
    check_val("over_p_ign", {6'd0, state}, 8'h03);
    key_event = key_word(1'b0, 1'b0, K_R); cyc();
    check_val("r_state", {6'd0, state}, 8'h00);
    check_val("r_clr", {7'd0, clr}, 8'd1);
    check_val("r_winner", {6'd0, winner}, 8'h00);
    cyc();
    check_val("r_clr_once", {7'd0, clr}, 8'd0);

    // Level select wraps after 16 increments
    for (int i = 0; i < 17; i++) begin
      key_event = key_word(1'b0, 1'b0, K_W); cyc();
      key_event = key_word(1'b0, 1'b1, K_W); cyc();
    end
    check_val("sel_wrap", {4'd0, sel}, 8'h01);
    key_event = key_word(1'b0, 1'b0, K_SPACE); cyc();
    key_event = key_word(1'b0, 1'b0, K_W); cyc();
    check_val("run_rot", {4'd0, cmd1}, 8'h08);
    check_val("sel_frozen", {4'd0, sel}, 8'h01);

    // Music toggles and survives R; R beats a same-cycle top-out
    key_event = key_word(1'b0, 1'b0, K_M); cyc();
    check_val("music_on", {7'd0, music_en}, 8'd1);
    key_event = key_word(1'b0, 1'b0, K_R); over2 = 1'b1; cyc();
    over2 = 1'b0;
    check_val("r_over_state", {6'd0, state}, 8'h00);
    check_val("r_over_winner", {6'd0, winner}, 8'h00);
    check_val("music_kept", {7'd0, music_en}, 8'd1);
    key_event = key_word(1'b0, 1'b0, K_M); cyc();
    check_val("music_off", {7'd0, music_en}, 8'd0);

    // Reset arriving on the edge a repeat is due suppresses the pulse
    key_event = key_word(1'b0, 1'b0, K_SPACE); cyc();
    key_event = key_word(1'b0, 1'b0, K_S);
    for (int k = 1; k <= 10; k++) cyc();
    reset = 1'b1; cyc();
    check_val("rst_mid_cmd", {4'd0, cmd1}, 8'h00);
    check_val("rst_mid_state", {6'd0, state}, 8'h00);
    check_val("rst_mid_clr", {7'd0, clr}, 8'd1);
    key_event = 11'd0;
    reset = 1'b0; cyc();
    check_val("rst_mid_music", {7'd0, music_en}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter REP_DLY, 25_000_000, cycles a held drop key waits before its first auto-repeat.
REQ-002 Parameter REP_PER, 5_000_000, cycles between auto-repeats after the first one.
REQ-003 Port clk  input  1  system clock, 100 MHz; every register is clocked on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port key_event  input  11  keyboard word: [10] valid, [9] E0 extended, [8] release, [7:0] scan code, bit-reversed (scan code = {ke[0],ke[1],...,ke[7]}).
REQ-006 Port over1, over2  input  1 each  player 1 / player 2 top-out level.
REQ-007 Port cmd1, cmd2  output  4 each  one-cycle command pulses {rot,left,drop,right} for player 1 / player 2.
REQ-008 Port run  output  1  high while state is RUN.
REQ-009 Port clr  output  1  one-cycle clear pulse to players, score RAMs and timer.
REQ-010 Port music_en  output  1  music enable, level.
REQ-011 Port sel  output  4  level select.
REQ-012 Port state  output  2  FSM state.
REQ-013 Port winner  output  2  game result: 01 P1, 10 P2, 11 tie, 00 none.

Function
REQ-014 Acceptance: a key event is accepted when key_event[10]=1 and key_event[9:0] differs from the last accepted value; the held value does not re-trigger.
REQ-015 Key map: W/A/S/D (1D/1C/1B/23) drive player 1; E0+75/6B/72/74 drive player 2; the same codes without E0 are ignored; M=3A, P=4D, Space=29, R=2D.
REQ-016 Press events (key_event[8]=0) act; release events only clear the matching held-drop flag.
REQ-017 States: IDLE=00, RUN=01, PAUSE=10, OVER=11.
REQ-018 Transitions: IDLE -Space-> RUN; RUN -P-> PAUSE; PAUSE -Space-> RUN; RUN -(over1|over2)-> OVER; any state -R-> IDLE.
REQ-019 R also pulses clr for exactly one cycle and clears winner and sel.
REQ-020 When R and an over flag occur in the same cycle, R wins.
REQ-021 In RUN, each accepted press drives its cmd bit high for exactly one cycle, registered in the cycle after acceptance (1-cycle latency); cmd1/cmd2 are all-zero in every other state.
REQ-022 Auto-repeat: while a drop key (S or E0+72) is held in RUN, a further drop pulse follows REP_DLY cycles after the press, then one every REP_PER cycles, until the key is released or the state leaves RUN.
REQ-023 The repeat counter restarts from zero on each accepted press and holds while in PAUSE.
REQ-024 In IDLE, a W or E0+75 press increments sel modulo 16 (15 wraps to 0); sel is frozen outside IDLE.
REQ-025 M toggles music_en in any state; music_en is unaffected by R.
REQ-026 winner is latched on entry to OVER: over1 only -> 10; over2 only -> 01; both in the same cycle -> 11.
REQ-027 Over flags are ignored outside RUN.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, cmd1=cmd2=0, run=0, clr=1 for that cycle then 0, music_en=0, sel=0, winner=00, held flags and repeat counters=0, last-accepted register=0.
REQ-029 Reset asserted mid-repeat or mid-game takes effect on the next edge; no cmd pulse is emitted in that cycle.

Structure
REQ-030 The shared package game_pkg holds the scan-code constants, the state encoding and the cmd bit indices (ROT=3, LEFT=2, DROP=1, RIGHT=0).
REQ-031 The sub-module key_repeat (held flag plus repeat counter, parameterised by REP_DLY and REP_PER) is instantiated once per player.
REQ-032 Target size is 120-400 lines of RTL.

Verification (REP_DLY=10, REP_PER=4)
REQ-033 Reset, then Space (0x29 reversed) -> state 00->01 one cycle after acceptance; run=1; clr pulsed once at reset.
REQ-034 In RUN, press A, then E0+6B -> cmd1=0100 for one cycle, then cmd2=0100 for one cycle; the same word held for 50 cycles -> no further pulses.
REQ-035 In RUN, hold S for 30 cycles, then release -> cmd1 drop pulses at +1, +11, +15, +19, +23, +27 cycles; none after release.
REQ-036 In IDLE, W pressed 17 times with distinct events between -> sel=1 (wrap check); Space, then W -> sel stays 1 and cmd1=1000.
REQ-037 In RUN, assert over1 and over2 in the same cycle -> state=11, winner=11; P ignored; R -> state=00, clr pulse, winner=00.
REQ-038 In RUN, R and over2 in the same cycle -> state=00, winner=00; M before and after -> music_en 0->1, retained across R.
